// File: rtl/proc_check_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | proc_check_pkg: shared encodings for the run-and-check monitor. Rev 1.0   |
// +--------------------------------------------------------------------------+
package proc_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_MISMATCH    = 2'd1;
    localparam logic [1:0] ERR_RUN_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ACK_TIMEOUT = 2'd3;

    localparam logic SEL_REG = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    // A single-entry table still needs a one-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/proc_check_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | proc_check_monitor_if: debug read handshake toward the processor. Rev 1.0 |
// +--------------------------------------------------------------------------+
interface proc_check_monitor_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              dbg_req;
    logic              dbg_sel;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    modport master (output dbg_req, dbg_sel, dbg_addr, input dbg_ack, dbg_rdata);
    modport slave  (input dbg_req, dbg_sel, dbg_addr, output dbg_ack, dbg_rdata);
endinterface
`default_nettype wire

// File: rtl/proc_check_monitor_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | proc_check_table: check entries with valid bits and next-valid search.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module proc_check_table
    import proc_check_pkg::*;
#(
    parameter int NUM_CHECKS = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             we,
    input  logic [idx_w(NUM_CHECKS)-1:0]     wr_idx,
    input  logic                             wr_sel,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_expect,
    input  logic [idx_w(NUM_CHECKS)-1:0]     rd_idx,
    output logic                             rd_sel,
    output logic [ADDR_W-1:0]                rd_addr,
    output logic [DATA_W-1:0]                rd_expect,
    input  logic [idx_w(NUM_CHECKS):0]       find_from,
    output logic                             find_ok,
    output logic [idx_w(NUM_CHECKS)-1:0]     find_idx
);
    localparam int IW = idx_w(NUM_CHECKS);

    logic [NUM_CHECKS-1:0] valid;
    logic                  sel_mem  [NUM_CHECKS];
    logic [ADDR_W-1:0]     addr_mem [NUM_CHECKS];
    logic [DATA_W-1:0]     exp_mem  [NUM_CHECKS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                sel_mem[i]  <= 1'b0;
                addr_mem[i] <= '0;
                exp_mem[i]  <= '0;
            end
        end else if (we && (int'(wr_idx) < NUM_CHECKS)) begin
            valid[wr_idx]    <= 1'b1;
            sel_mem[wr_idx]  <= wr_sel;
            addr_mem[wr_idx] <= wr_addr;
            exp_mem[wr_idx]  <= wr_expect;
        end
    end

    always_comb begin
        rd_sel    = 1'b0;
        rd_addr   = '0;
        rd_expect = '0;
        if (int'(rd_idx) < NUM_CHECKS) begin
            rd_sel    = sel_mem[rd_idx];
            rd_addr   = addr_mem[rd_idx];
            rd_expect = exp_mem[rd_idx];
        end
    end

    // Descending scan so the lowest valid index at or above find_from wins.
    always_comb begin
        find_ok  = 1'b0;
        find_idx = '0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (valid[i] && (i >= int'(find_from))) begin
                find_ok  = 1'b1;
                find_idx = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/proc_check_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | proc_check_monitor: runs the processor to halt/timeout, then reads back  |
// | and compares the check table. Rev 1.0                                    |
// +--------------------------------------------------------------------------+
module proc_check_monitor
    import proc_check_pkg::*;
#(
    parameter int                 PC_W          = 16,
    parameter int                 INSTR_W       = 32,
    parameter int                 STATE_W       = 4,
    parameter int                 DATA_W        = 32,
    parameter int                 ADDR_W        = 8,
    parameter int                 NUM_CHECKS    = 4,
    parameter int                 MAX_CYCLES    = 64,
    parameter int                 STABLE_CYCLES = 4,
    parameter logic [STATE_W-1:0] HALT_STATE    = 4'hF,
    parameter int                 ACK_TIMEOUT   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [PC_W-1:0]              pc_value,
    input  logic [INSTR_W-1:0]           current_instruction,
    input  logic [STATE_W-1:0]           current_state,
    input  logic                         cfg_we,
    input  logic [idx_w(NUM_CHECKS)-1:0] cfg_idx,
    input  logic                         cfg_sel,
    input  logic [ADDR_W-1:0]            cfg_addr,
    input  logic [DATA_W-1:0]            cfg_expect,
    proc_check_monitor_if.master         dbg,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [1:0]                   err_code,
    output logic [idx_w(NUM_CHECKS)-1:0] fail_idx,
    output logic [DATA_W-1:0]            fail_data,
    output logic [31:0]                  cycle_count,
    output logic [INSTR_W-1:0]           last_instr
);
    localparam int IW = idx_w(NUM_CHECKS);

    state_t            state, state_nxt;
    logic              done_nxt, pass_nxt, req, req_nxt, sel, sel_nxt;
    logic [1:0]        err_nxt;
    logic [IW-1:0]     fidx_nxt, cur_idx, cur_nxt, rd_idx, find_idx;
    logic [IW:0]       search_from, from_nxt;
    logic [DATA_W-1:0] fdata_nxt, rd_expect;
    logic [ADDR_W-1:0] addr, addr_nxt, rd_addr;
    logic [31:0]       cnt_nxt, cnt_inc, stab_cnt, stab_nxt, stab_inc, ack_cnt, ack_nxt;
    logic [PC_W-1:0]   prev_pc;
    logic [INSTR_W-1:0] li_nxt;
    logic              rd_sel, find_ok, halt, idle_like;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_CHECK);
    assign cnt_inc   = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
    assign stab_inc  = (pc_value == prev_pc) ? stab_cnt + 32'd1 : 32'd0;
    assign halt      = (current_state == HALT_STATE) || (stab_inc >= 32'(STABLE_CYCLES - 1));
    assign rd_idx    = req ? cur_idx : find_idx;

    assign dbg.dbg_req  = req;
    assign dbg.dbg_sel  = sel;
    assign dbg.dbg_addr = addr;

    proc_check_table #(
        .NUM_CHECKS (NUM_CHECKS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .we        (cfg_we && idle_like),
        .wr_idx    (cfg_idx),
        .wr_sel    (cfg_sel),
        .wr_addr   (cfg_addr),
        .wr_expect (cfg_expect),
        .rd_idx    (rd_idx),
        .rd_sel    (rd_sel),
        .rd_addr   (rd_addr),
        .rd_expect (rd_expect),
        .find_from (search_from),
        .find_ok   (find_ok),
        .find_idx  (find_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_code    <= ERR_NONE;
            fail_idx    <= '0;
            fail_data   <= '0;
            cycle_count <= '0;
            last_instr  <= '0;
            stab_cnt    <= '0;
            ack_cnt     <= '0;
            cur_idx     <= '0;
            search_from <= '0;
            req         <= 1'b0;
            sel         <= 1'b0;
            addr        <= '0;
            prev_pc     <= '0;
        end else begin
            state       <= state_nxt;
            done        <= done_nxt;
            pass        <= pass_nxt;
            err_code    <= err_nxt;
            fail_idx    <= fidx_nxt;
            fail_data   <= fdata_nxt;
            cycle_count <= cnt_nxt;
            last_instr  <= li_nxt;
            stab_cnt    <= stab_nxt;
            ack_cnt     <= ack_nxt;
            cur_idx     <= cur_nxt;
            search_from <= from_nxt;
            req         <= req_nxt;
            sel         <= sel_nxt;
            addr        <= addr_nxt;
            prev_pc     <= pc_value;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = done;
        pass_nxt  = pass;
        err_nxt   = err_code;
        fidx_nxt  = fail_idx;
        fdata_nxt = fail_data;
        cnt_nxt   = cycle_count;
        li_nxt    = last_instr;
        stab_nxt  = stab_cnt;
        ack_nxt   = ack_cnt;
        cur_nxt   = cur_idx;
        from_nxt  = search_from;
        req_nxt   = req;
        sel_nxt   = sel;
        addr_nxt  = addr;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                    err_nxt   = ERR_NONE;
                    fidx_nxt  = '0;
                    fdata_nxt = '0;
                    cnt_nxt   = '0;
                    stab_nxt  = '0;
                end
            end
            ST_RUN: begin
                cnt_nxt  = cnt_inc;
                stab_nxt = stab_inc;
                // Halt is tested first so it beats a timeout on the same cycle.
                if (halt) begin
                    state_nxt = ST_CHECK;
                    li_nxt    = current_instruction;
                    from_nxt  = '0;
                end else if (cnt_inc >= 32'(MAX_CYCLES)) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    err_nxt   = ERR_RUN_TIMEOUT;
                end
            end
            ST_CHECK: begin
                if (!req) begin
                    if (find_ok) begin
                        req_nxt  = 1'b1;
                        sel_nxt  = rd_sel;
                        addr_nxt = rd_addr;
                        cur_nxt  = find_idx;
                        ack_nxt  = '0;
                    end else begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        pass_nxt  = 1'b1;
                    end
                end else if (dbg.dbg_ack) begin
                    req_nxt = 1'b0;
                    if (dbg.dbg_rdata != rd_expect) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        err_nxt   = ERR_MISMATCH;
                        fidx_nxt  = cur_idx;
                        fdata_nxt = dbg.dbg_rdata;
                    end else begin
                        from_nxt = {1'b0, cur_idx} + {{IW{1'b0}}, 1'b1};
                    end
                end else if (ack_cnt + 32'd1 >= 32'(ACK_TIMEOUT)) begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    err_nxt   = ERR_ACK_TIMEOUT;
                    fidx_nxt  = cur_idx;
                end else begin
                    ack_nxt = ack_cnt + 32'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/proc_check_monitor.md
Name: proc_check_monitor

Overview:
Parametrised, synthesizable run-and-check monitor for the custom-ISA processor.
- Watches the processor debug outputs (pc_value, current_instruction, current_state) and counts cycles.
- Detects halt or timeout.
- Reads back a programmable list of register/memory locations through a debug read port and compares each against an expected value.
- Reports pass/fail. Replaces hard-coded end-of-sim checks and works both on the bench and on FPGA.

Parameters:
PC_W, 16, width of pc_value
INSTR_W, 32, width of current_instruction
STATE_W, 4, width of current_state
DATA_W, 32, register/memory data width
ADDR_W, 8, debug read address width (register index or memory word address)
NUM_CHECKS, 4, number of check-table entries (>=1)
MAX_CYCLES, 64, run timeout in clk cycles after start
STABLE_CYCLES, 4, consecutive cycles of unchanged pc_value that count as halt
HALT_STATE, 4'hF, current_state value that signals halt
ACK_TIMEOUT, 16, max cycles waiting for dbg_ack

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin a monitored run
pc_value  in  PC_W  processor PC
current_instruction  in  INSTR_W  processor instruction (latched for reporting)
current_state  in  STATE_W  processor FSM state
cfg_we  in  1  check-table write strobe
cfg_idx  in  clog2(NUM_CHECKS)  entry index
cfg_sel  in  1  0 = register, 1 = memory
cfg_addr  in  ADDR_W  location to check
cfg_expect  in  DATA_W  expected value
dbg_req  out  1  debug read request
dbg_sel  out  1  register/memory select for the read
dbg_addr  out  ADDR_W  read address
dbg_ack  in  1  read data valid
dbg_rdata  in  DATA_W  read data
busy  out  1  high in RUN/CHECK
done  out  1  sticky until next start or reset
pass  out  1  valid when done
err_code  out  2  0 none, 1 mismatch, 2 run timeout, 3 ack timeout
fail_idx  out  clog2(NUM_CHECKS)  failing entry
fail_data  out  DATA_W  dbg_rdata of the failing entry
cycle_count  out  32  cycles spent in RUN, saturating
last_instr  out  INSTR_W  current_instruction sampled at halt

Behaviour:
- Reset (async) forces IDLE and clears all outputs to 0, including dbg_req. It also clears all entry valid bits. Reset mid-run or mid-read aborts with no done.
- cfg_we writes an entry and sets its valid bit. It is accepted only in IDLE/DONE and ignored while busy.
- If cfg_we and start occur in the same cycle, the write is applied and the run uses it.
- States: IDLE -> RUN -> CHECK -> DONE; DONE -> RUN on start.
- start in IDLE/DONE:
  - clears done, pass, err_code, fail_*, cycle_count and the stable counter;
  - sets busy the next cycle;
  - start while busy is ignored.
- RUN:
  - cycle_count increments every cycle.
  - Stable counter: increments when pc_value equals its previous-cycle value, else clears.
  - Halt is current_state == HALT_STATE, or stable counter reaching STABLE_CYCLES-1 (i.e. STABLE_CYCLES consecutive equal samples). On halt, latch last_instr and go to CHECK.
  - If cycle_count reaches MAX_CYCLES without halt: DONE, err_code=2, pass=0. Halt detected on that same cycle wins over timeout.
- CHECK: scans entries 0..NUM_CHECKS-1 in order and skips invalid entries with zero cycle cost.
  - For each valid entry, assert dbg_req with dbg_sel/dbg_addr and hold them stable until dbg_ack is sampled high.
  - Deassert dbg_req in the cycle after ack. There is at least one idle cycle between requests.
  - On ack, compare dbg_rdata with the expected value (full DATA_W).
    - Mismatch: DONE, err_code=1, fail_idx and fail_data captured.
    - Match: next entry.
  - If no ack within ACK_TIMEOUT cycles of req: drop req, DONE, err_code=3, fail_idx set.
  - All valid entries matched (including zero valid entries): DONE, pass=1, err_code=0.
- DONE: busy=0, done=1; outputs hold until start or reset.

Decomposition:
- Package proc_check_pkg holds:
  - state encoding (IDLE, RUN, CHECK, DONE);
  - err_code constants;
  - SEL_REG/SEL_MEM;
  - the clog2-based index-width helper.
- One sub-module, proc_check_table: NUM_CHECKS-entry register array with valid bits, a write port, a combinational read port, and a find-next-valid-from-index output.

Test Plan:
- Program entry0 = mem[25] expect 32'h4, entry1 = reg0 expect 32'h4. Processor halts (state=4'hF) at cycle 40 with those values, ack 1 cycle later -> done=1, pass=1, err_code=0, cycle_count=40.
- Same program, reg0 returns 32'h3 -> done=1, pass=0, err_code=1, fail_idx=1, fail_data=32'h3. No dbg_req is issued after entry1.
- pc_value keeps changing and state is never 4'hF -> done at cycle_count=64, err_code=2, and dbg_req is never asserted.
- pc_value frozen at 16'h0010 from cycle 10 -> halt after 4 equal samples; CHECK begins and last_instr equals the instruction at halt.
- dbg_ack withheld on entry0 -> dbg_req stays high for 16 cycles, then err_code=3, fail_idx=0.
- Assert reset during CHECK with dbg_req high -> dbg_req, busy and done all 0 immediately. A following start with no cfg writes -> pass=1 (no valid entries).
